// File: rtl/hc_pkg.sv
// hc_pkg: shared state encoding and default timing constants for the hybrid controller
package hc_pkg;
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_DT_P = 3'd1;
   localparam logic [2:0] ST_P_ON = 3'd2;
   localparam logic [2:0] ST_DT_N = 3'd3;
   localparam logic [2:0] ST_N_ON = 3'd4;
   typedef enum logic [2:0] {
      IDLE = ST_IDLE,
      DT_P = ST_DT_P,
      P_ON = ST_P_ON,
      DT_N = ST_DT_N,
      N_ON = ST_N_ON
   } state_t;
   localparam int DEF_DT_WIDTH  = 8;
   localparam int DEF_MIN_HOLD  = 50;
   localparam int DEF_CNT_WIDTH = 16;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for asynchronous inputs, async active-high reset
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] meta;
   always_ff @(posedge clk or posedge rst)
      if (rst) {q, meta} <= '0;
      else     {q, meta} <= {meta, d};
endmodule

// File: rtl/sigma_gate_driver.sv
// sigma_gate_driver: sigma-controlled complementary gate driver with dead time,
// minimum on-time and switching-event counter
module sigma_gate_driver
   import hc_pkg::*;
#(
   parameter int DT_WIDTH  = DEF_DT_WIDTH,
   parameter int MIN_HOLD  = DEF_MIN_HOLD,
   parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
   input  logic                 i_CLK,
   input  logic                 i_RESET,
   input  logic                 i_enable,
   input  logic                 i_sigma,
   input  logic [DT_WIDTH-1:0]  i_deadtime,
   output logic                 o_gate_p,
   output logic                 o_gate_n,
   output logic                 o_busy,
   output logic [CNT_WIDTH-1:0] o_sw_count
);
   localparam int HW = $clog2(MIN_HOLD + 1);
   localparam logic [HW-1:0] HOLD = HW'(MIN_HOLD);
   localparam logic [DT_WIDTH-1:0] DT_ONE = DT_WIDTH'(1);
   state_t state, state_n;
   logic [DT_WIDTH-1:0] dt_cnt, dt_n, dt_load;
   logic [HW-1:0] dwell_cnt, dwell_n;
   logic [CNT_WIDTH-1:0] sw_n;
   logic sigma_s, dwell_done;
   sync_2ff #(.WIDTH(1)) u_sync (
      .clk(i_CLK),
      .rst(i_RESET),
      .d  (i_sigma),
      .q  (sigma_s)
   );
   assign dt_load    = (i_deadtime == '0) ? DT_ONE : i_deadtime;
   assign dwell_done = dwell_cnt == HOLD;
   always_ff @(posedge i_CLK or posedge i_RESET)
      if (i_RESET) begin
         state      <= IDLE;
         dt_cnt     <= '0;
         dwell_cnt  <= '0;
         o_sw_count <= '0;
         o_gate_p   <= 1'b0;
         o_gate_n   <= 1'b0;
         o_busy     <= 1'b0;
      end else begin
         state      <= state_n;
         dt_cnt     <= dt_n;
         dwell_cnt  <= dwell_n;
         o_sw_count <= sw_n;
         o_gate_p   <= state_n == P_ON;
         o_gate_n   <= state_n == N_ON;
         o_busy     <= (state_n == DT_P) || (state_n == DT_N);
      end
   // Dead-time expiry re-reads sigma_s, so a revert during dead time returns to the old leg.
   always_comb begin
      state_n = state;
      dt_n    = dt_cnt;
      dwell_n = dwell_cnt;
      sw_n    = o_sw_count;
      if (!i_enable) begin
         state_n = IDLE;
         dt_n    = '0;
         dwell_n = '0;
      end else begin
         case (state)
            IDLE: begin
               state_n = sigma_s ? DT_P : DT_N;
               dt_n    = dt_load;
            end
            DT_P, DT_N:
               if (dt_cnt <= DT_ONE) begin
                  state_n = sigma_s ? P_ON : N_ON;
                  dt_n    = '0;
                  dwell_n = '0;
                  sw_n    = o_sw_count + 1'b1;
               end else begin
                  dt_n = dt_cnt - 1'b1;
               end
            P_ON, N_ON: begin
               dwell_n = dwell_done ? dwell_cnt : dwell_cnt + 1'b1;
               if (dwell_done && (sigma_s != (state == P_ON))) begin
                  state_n = (state == P_ON) ? DT_N : DT_P;
                  dt_n    = dt_load;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sigma_gate_driver.sv
// tb_sigma_gate_driver: directed and random stimulus checked cycle by cycle
// against a behavioural model of the gate driver.
module tb_sigma_gate_driver;
   localparam int DTW = 8;
   localparam int MH  = 50;
   localparam int CW  = 4;
   logic clk = 1'b0;
   logic rst, en, sig;
   logic [DTW-1:0] dt;
   logic gp, gn, busy;
   logic [CW-1:0] cnt;
   int checks = 0;
   int failures = 0;
   int mode, dead, ontime, mcount;
   logic leg, h1, h2;
   always #5 clk = ~clk;
   sigma_gate_driver #(.DT_WIDTH(DTW), .MIN_HOLD(MH), .CNT_WIDTH(CW)) dut (
      .i_CLK     (clk),
      .i_RESET   (rst),
      .i_enable  (en),
      .i_sigma   (sig),
      .i_deadtime(dt),
      .o_gate_p  (gp),
      .o_gate_n  (gn),
      .o_busy    (busy),
      .o_sw_count(cnt)
   );
   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
      end
   endtask
   // Model: mode 0=off, 1=dead time, 2=gate on; leg 1=P, 0=N; sigma seen two edges late.
   task automatic model_reset();
      mode = 0; dead = 0; ontime = 0; mcount = 0; leg = 1'b0; h1 = 1'b0; h2 = 1'b0;
   endtask
   task automatic model_edge();
      int d;
      logic ms;
      d  = (dt == 0) ? 1 : int'(dt);
      ms = h2;
      if (!en) begin
         mode = 0; dead = 0; ontime = 0;
      end else if (mode == 0) begin
         mode = 1; dead = d;
      end else if (mode == 1) begin
         if (dead <= 1) begin
            mode = 2; leg = ms; ontime = 0; mcount++;
         end else dead--;
      end else begin
         if (ontime >= MH && ms != leg) begin
            mode = 1; dead = d;
         end else if (ontime < MH) ontime++;
      end
      h2 = h1;
      h1 = sig;
   endtask
   task automatic cyc();
      logic [CW+2:0] e;
      @(posedge clk);
      if (rst) model_reset();
      else model_edge();
      #1;
      e = {mode == 2 && leg, mode == 2 && !leg, mode == 1, CW'(mcount)};
      check("outs", int'({gp, gn, busy, cnt}), int'(e));
      check("overlap", int'(gp & gn), 0);
   endtask
   task automatic run_until(input string tag, input int sel, input logic val,
                            input int limit, output int n);
      n = 0;
      while (((sel == 0) ? gp : gn) !== val && n < limit) begin
         cyc();
         n++;
      end
      check(tag, int'((sel == 0) ? gp : gn), int'(val));
   endtask
   task automatic chatter(input logic final_v);
      for (int i = 0; i < 8; i++) begin
         repeat (5) cyc();
         sig = (i == 7) ? final_v : ~sig;
      end
   endtask
   initial begin
      int n, n2, mc;
      rst = 1'b1; en = 1'b1; sig = 1'b1; dt = 8'd10;
      model_reset();
      #2;
      check("rst_outs", int'({gp, gn, busy, cnt}), 0);
      repeat (2) cyc();
      rst = 1'b0;
      // one IDLE edge, then the full 10-cycle dead time
      run_until("rst_p_up", 0, 1'b1, 100, n);
      check("rst_p_lat", n, 11);
      repeat (200) cyc();
      sig = 1'b0;
      run_until("tog_p_down", 0, 1'b0, 20, n);
      check("tog_p_fall_lat", n, 3);
      run_until("tog_n_up", 1, 1'b1, 40, n);
      check("tog_dead_n", n, 10);
      repeat (200) cyc();
      sig = 1'b1;
      run_until("tog_n_down", 1, 1'b0, 20, n);
      check("tog_n_fall_lat", n, 3);
      run_until("tog_p_up", 0, 1'b1, 40, n);
      check("tog_dead_p", n, 10);
      mc = mcount;
      chatter(1'b1);
      repeat (100) cyc();
      check("chat1_p_held", int'(gp), 1);
      check("chat1_count", int'(cnt), mc % (1 << CW));
      sig = 1'b0;
      run_until("to_n", 1, 1'b1, 40, n);
      repeat (60) cyc();
      sig = 1'b1;
      run_until("to_p", 0, 1'b1, 40, n);
      chatter(1'b0);
      run_until("chat0_p_down", 0, 1'b0, 100, n);
      check("chat0_hold", 40 + n, MH + 1);
      run_until("chat0_n_up", 1, 1'b1, 40, n);
      check("chat0_dead", n, 10);
      dt = 8'd0;
      repeat (60) cyc();
      sig = 1'b1;
      run_until("dt0_n_down", 1, 1'b0, 20, n);
      run_until("dt0_p_up", 0, 1'b1, 20, n);
      check("dt0_gap", n, 1);
      dt = 8'd255;
      repeat (60) cyc();
      sig = 1'b0;
      run_until("dt255_p_down", 0, 1'b0, 20, n);
      repeat (10) cyc();
      dt = 8'd3;
      run_until("dt255_n_up", 1, 1'b1, 400, n2);
      check("dt255_gap", n2 + 10, 255);
      dt = 8'd20;
      repeat (60) cyc();
      sig = 1'b1;
      run_until("en_p_up", 0, 1'b1, 60, n);
      repeat (60) cyc();
      sig = 1'b0;
      run_until("en_p_down", 0, 1'b0, 20, n);
      repeat (5) cyc();
      check("en_in_dt_n", int'(busy), 1);
      en = 1'b0;
      cyc();
      check("en_off_outs", int'({gp, gn, busy}), 0);
      repeat (10) cyc();
      en = 1'b1;
      run_until("en_n_up", 1, 1'b1, 60, n);
      check("en_full_dead", n, 21);
      repeat (60) cyc();
      sig = 1'b1;
      run_until("arst_p_up", 0, 1'b1, 60, n);
      #2 rst = 1'b1;
      model_reset();
      #1;
      check("arst_outs", int'({gp, gn, busy, cnt}), 0);
      #1 rst = 1'b0;
      repeat (40) cyc();
      mc = mcount;
      dt = 8'd2;
      for (int i = 0; i < 17; i++) begin
         repeat (MH + 5) cyc();
         sig = ~sig;
         run_until("wrap_up", sig ? 0 : 1, 1'b1, 40, n);
      end
      check("wrap_count", int'(cnt), (mc + 17) % (1 << CW));
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(39) == 0) sig = ~sig;
         if (!en && $urandom_range(7) == 0) en = 1'b1;
         else if (en && $urandom_range(299) == 0) en = 1'b0;
         if ($urandom_range(99) == 0) dt = DTW'($urandom_range(15));
         cyc();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
